// File: rtl/multicore_sobel_ocimem_pkg.sv
// rtl/multicore_sobel_ocimem_pkg.sv - shared types and constants for the CPU_1 OCI memory controller
package multicore_sobel_ocimem_pkg;

    localparam int OCIMEM_DEPTH = 256;
    localparam int OCIMEM_AW    = 8;
    localparam int OCIMEM_DW    = 32;
    localparam int OCIMEM_BE    = OCIMEM_DW / 8;
    localparam int JDO_W        = 38;

    localparam int JDO_RD_BIT   = 35;
    localparam int JDO_ADDR_HI  = 33;
    localparam int JDO_ADDR_LO  = 26;
    localparam int JDO_DATA_HI  = 34;
    localparam int JDO_DATA_LO  = 3;

    localparam int STAT_READY_BIT = 0;
    localparam int STAT_ERROR_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_RD,
        ST_JTAG_CAP
    } ocimem_state_e;

endpackage

// File: rtl/multicore_sobel_cpu_1_ociram_sp.sv
// rtl/multicore_sobel_cpu_1_ociram_sp.sv - 256x32 single-port monitor RAM, byte enables, registered read
module multicore_sobel_cpu_1_ociram_sp
    import multicore_sobel_ocimem_pkg::*;
(
    input  logic                 clk,
    input  logic [OCIMEM_AW-1:0] addr_i,
    input  logic                 we_i,
    input  logic [OCIMEM_BE-1:0] be_i,
    input  logic [OCIMEM_DW-1:0] wdata_i,
    output logic [OCIMEM_DW-1:0] q_o
);

    logic [OCIMEM_DW-1:0] mem [OCIMEM_DEPTH];

    // Read returns the old word on a same-address write (M9K read-during-write behaviour).
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < OCIMEM_BE; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        q_o <= mem[addr_i];
    end

endmodule

// File: rtl/multicore_sobel_cpu_1_ocimem.sv
// rtl/multicore_sobel_cpu_1_ocimem.sv - OCI memory controller arbitrating JTAG debug and CPU Avalon access
module multicore_sobel_cpu_1_ocimem
    import multicore_sobel_ocimem_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [JDO_W-1:0]     jdo,
    input  logic                 take_action_ocimem_a,
    input  logic                 take_no_action_ocimem_a,
    input  logic                 take_action_ocimem_b,
    input  logic [8:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [OCIMEM_DW-1:0] writedata,
    input  logic [OCIMEM_BE-1:0] byteenable,
    input  logic                 debugaccess,
    output logic [OCIMEM_DW-1:0] readdata,
    output logic                 waitrequest,
    output logic [OCIMEM_DW-1:0] MonDReg,
    output logic                 monitor_ready,
    output logic                 monitor_error
);

    ocimem_state_e        state_q, state_d;
    logic [OCIMEM_AW-1:0] mon_a_q, mon_a_d;
    logic [OCIMEM_DW-1:0] mon_d_q, mon_d_d;
    logic                 jtag_rd_q, jtag_rd_d;
    logic                 jtag_wr_q, jtag_wr_d;
    logic                 ready_q, ready_d;
    logic                 error_q, error_d;

    logic [OCIMEM_AW-1:0] ram_addr;
    logic                 ram_we;
    logic [OCIMEM_BE-1:0] ram_be;
    logic [OCIMEM_DW-1:0] ram_wdata;
    logic [OCIMEM_DW-1:0] ram_q;
    logic [OCIMEM_DW-1:0] status;
    logic                 pending;
    logic                 unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LO-1:0]};

    multicore_sobel_cpu_1_ociram_sp u_ram (
        .clk     (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .q_o     (ram_q)
    );

    always_comb begin
        state_d   = state_q;
        mon_a_d   = mon_a_q;
        mon_d_d   = mon_d_q;
        jtag_rd_d = jtag_rd_q;
        jtag_wr_d = jtag_wr_q;
        ready_d   = ready_q;
        error_d   = error_q;
        ram_addr  = address[OCIMEM_AW-1:0];
        ram_we    = 1'b0;
        ram_be    = byteenable;
        ram_wdata = writedata;
        readdata  = '0;
        pending   = jtag_rd_q | jtag_wr_q;

        status                 = '0;
        status[STAT_READY_BIT] = ready_q;
        status[STAT_ERROR_BIT] = error_q;
        status[STAT_BUSY_BIT]  = pending;

        waitrequest = (read && state_q != ST_CPU_RD) || (write && pending)
                   || (state_q == ST_JTAG_CAP);

        unique case (state_q)
            ST_IDLE: begin
                if (jtag_wr_q) begin
                    ram_addr  = mon_a_q;
                    ram_we    = 1'b1;
                    ram_be    = '1;
                    ram_wdata = mon_d_q;
                    jtag_wr_d = 1'b0;
                    mon_a_d   = mon_a_q + 8'd1;
                end else if (jtag_rd_q) begin
                    ram_addr = mon_a_q;
                    state_d  = ST_JTAG_CAP;
                end else if (read) begin
                    state_d = ST_CPU_RD;
                end else if (write) begin
                    if (!address[8]) begin
                        ram_we = debugaccess;
                    end else begin
                        ready_d = writedata[0];
                        error_d = writedata[1];
                    end
                end
            end
            ST_JTAG_CAP: begin
                mon_d_d   = ram_q;
                jtag_rd_d = 1'b0;
                mon_a_d   = mon_a_q + 8'd1;
                state_d   = ST_IDLE;
            end
            ST_CPU_RD: begin
                readdata = address[8] ? status : ram_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new strobe replaces whatever the FSM would have done to the same fields.
        if (take_action_ocimem_a) begin
            mon_a_d   = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
            jtag_rd_d = jdo[JDO_RD_BIT];
        end
        if (take_no_action_ocimem_a) begin
            jtag_rd_d = 1'b1;
        end
        if (take_action_ocimem_b) begin
            mon_d_d   = jdo[JDO_DATA_HI:JDO_DATA_LO];
            jtag_wr_d = 1'b1;
        end

        if (reset) begin
            waitrequest = 1'b1;
            readdata    = '0;
            ram_we      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mon_a_q   <= '0;
            mon_d_q   <= '0;
            jtag_rd_q <= 1'b0;
            jtag_wr_q <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mon_a_q   <= mon_a_d;
            mon_d_q   <= mon_d_d;
            jtag_rd_q <= jtag_rd_d;
            jtag_wr_q <= jtag_wr_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule
